// File: rtl/jtcop_colmix_pkg.sv
`default_nettype none
// ============================================================================
// jtcop_colmix_pkg
// Shared types and constants for the DECO-style priority colour mixer:
// fade FSM state encoding, full-brightness level, pipeline depth and a
// constant-foldable ceil(log2) helper.
// Revision: 1.0
// ============================================================================
package jtcop_colmix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } fade_state_t;

    localparam int LVL_MAX = 16;   // level at which colours pass unchanged
    localparam int MIX_DLY = 4;    // pxl_cen ticks from layer pixel to RGB

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtcop_colmix_fade.sv
`default_nettype none
// ============================================================================
// jtcop_colmix_fade
// Frame-stepped brightness fade. Counts LVBL falling edges, steps the
// level (0..16) once every i_rate+1 frames, and scales a 12-bit palette
// colour to 8-bit channels as ({c4,c4} * level) >> 4.
// Ports: clk, rst_n; i_lvbl; i_start/i_dir/i_rate fade control;
//        i_pal palette word {x,b4,g4,r4}; o_busy; o_red/o_green/o_blue.
// Revision: 1.0
// ============================================================================
module jtcop_colmix_fade (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_lvbl,
    input  logic        i_start,
    input  logic        i_dir,
    input  logic [3:0]  i_rate,
    input  logic [15:0] i_pal,
    output logic        o_busy,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue
);
    import jtcop_colmix_pkg::*;

    localparam logic [4:0] c_LVL_MAX = 5'(LVL_MAX);

    fade_state_t r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_rate;
    logic        r_dir;
    logic [4:0]  r_level;
    logic        r_lvbl_l;

    logic        w_vb_fall;
    logic [4:0]  w_next;
    logic [4:0]  w_end;

    assign w_vb_fall = r_lvbl_l & ~i_lvbl;
    assign w_end     = r_dir ? c_LVL_MAX : 5'd0;

    // Saturating one-level move in the armed direction
    always_comb begin
        w_next = r_level;
        if (r_dir) begin
            if (r_level != c_LVL_MAX) w_next = r_level + 5'd1;
        end else if (r_level != 5'd0) begin
            w_next = r_level - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_rate   <= 4'd0;
            r_dir    <= 1'b0;
            r_level  <= c_LVL_MAX;
            r_lvbl_l <= 1'b0;
        end else begin
            r_lvbl_l <= i_lvbl;
            // A new start always re-arms from WAIT; the level is kept so a
            // reversed fade continues from the current brightness.
            if (i_start) begin
                r_state <= WAIT;
                r_cnt   <= 4'd0;
                r_rate  <= i_rate;
                r_dir   <= i_dir;
            end else begin
                case (r_state)
                    IDLE: ;
                    WAIT: begin
                        if (w_vb_fall) begin
                            if (r_cnt == r_rate) r_state <= STEP;
                            else                 r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    STEP: begin
                        r_level <= w_next;
                        r_cnt   <= 4'd0;
                        r_state <= (w_next == w_end) ? IDLE : WAIT;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy = (r_state != IDLE);

    function automatic logic [7:0] fade_ch(input logic [3:0] c4, input logic [4:0] lvl);
        logic [12:0] prod;
        prod = {5'd0, c4, c4} * {8'd0, lvl};
        return 8'(prod >> 4);
    endfunction

    assign o_red   = fade_ch(4'(i_pal),      r_level);
    assign o_green = fade_ch(4'(i_pal >> 4), r_level);
    assign o_blue  = fade_ch(4'(i_pal >> 8), r_level);

endmodule
`default_nettype wire

// File: rtl/jtframe_dual_ram16.sv
`default_nettype none
// ============================================================================
// jtframe_dual_ram16
// 16-bit dual-port RAM on a single clock. Port 0 has byte-lane writes
// and read; port 1 is read-only. Reads are asynchronous so a read in the
// same clk as a write to the same address returns the old word.
// Ports: clk; i_data0/i_addr0/i_we0 -> o_q0; i_addr1 -> o_q1.
// Revision: 1.0
// ============================================================================
module jtframe_dual_ram16 #(
    parameter int AW = 10
)(
    input  logic          clk,
    input  logic [15:0]   i_data0,
    input  logic [AW-1:0] i_addr0,
    input  logic [1:0]    i_we0,
    output logic [15:0]   o_q0,
    input  logic [AW-1:0] i_addr1,
    output logic [15:0]   o_q1
);

    logic [15:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we0[0]) r_mem[i_addr0][7:0]  <= i_data0[7:0];
        if (i_we0[1]) r_mem[i_addr0][15:8] <= i_data0[15:8];
    end

    assign o_q0 = r_mem[i_addr0];
    assign o_q1 = r_mem[i_addr1];

endmodule
`default_nettype wire

// File: rtl/jtframe_prom.sv
`default_nettype none
// ============================================================================
// jtframe_prom
// Small run-time loadable PROM. Synchronous write port for loading,
// asynchronous read port for lookups. Contents are not affected by reset.
// Ports: clk; i_data/i_wr_addr/i_we load port; i_rd_addr -> o_q lookup.
// Revision: 1.0
// ============================================================================
module jtframe_prom #(
    parameter int DW = 4,
    parameter int AW = 8
)(
    input  logic          clk,
    input  logic [DW-1:0] i_data,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_we,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wr_addr] <= i_data;
    end

    assign o_q = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/jtcop_colmix_pri.sv
`default_nettype none
// ============================================================================
// jtcop_colmix_pri
// PROM-driven priority colour mixer. Four-stage pxl_cen pipeline:
//   S1 layer pixels + PROM address, S2 winner + palette address,
//   S3 palette word, S4 faded and blanked RGB.
// Ports: clk, rst_n, pxl_cen; LHBL/LVBL blanking in, LHBL_dly/LVBL_dly out;
//        layer_pxl/prisel/gfx_en video inputs; pal_cs/cpu_addr/cpu_dout/dsn
//        palette write, cpu_din readback; prog_addr/prog_data/prom_we PROM
//        load; fade_start/fade_dir/fade_rate, fade_busy; red/green/blue.
// Revision: 1.0
// ============================================================================
module jtcop_colmix_pri #(
    parameter int    LAYERS  = 4,
    parameter int    PSW     = 3,
    parameter int    PALW    = 10,
    parameter string SIMFILE = ""
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pxl_cen,
    input  logic                  LHBL,
    input  logic                  LVBL,
    input  logic [LAYERS*8-1:0]   layer_pxl,
    input  logic [PSW-1:0]        prisel,
    input  logic [LAYERS-1:0]     gfx_en,
    input  logic                  pal_cs,
    input  logic [PALW-1:0]       cpu_addr,
    input  logic [15:0]           cpu_dout,
    input  logic [1:0]            dsn,
    output logic [15:0]           cpu_din,
    input  logic [PSW+LAYERS:0]   prog_addr,
    input  logic [3:0]            prog_data,
    input  logic                  prom_we,
    input  logic                  fade_start,
    input  logic                  fade_dir,
    input  logic [3:0]            fade_rate,
    output logic                  fade_busy,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue,
    output logic                  LHBL_dly,
    output logic                  LVBL_dly
);
    import jtcop_colmix_pkg::*;

    localparam int c_WW  = clog2(LAYERS);
    localparam int c_PAW = PSW + LAYERS + 1;

    logic [LAYERS*8-1:0] r_pxl;
    logic [c_PAW-1:0]    r_prom_addr;
    logic [PALW-1:0]     r_pal_addr;
    logic [15:0]         r_pal;
    logic [7:0]          r_red, r_green, r_blue;
    logic [MIX_DLY-1:0]  r_hbl_sr, r_vbl_sr;
    logic [15:0]         r_cpu_din;

    logic [LAYERS-1:0]   w_op;
    logic [3:0]          w_prom_q;
    logic [c_WW-1:0]     w_win;
    logic [7:0]          w_win_pxl;
    logic                w_range_bd;
    logic                w_backdrop;
    logic [PALW-1:0]     w_pal_addr;
    logic [15:0]         w_pal_q, w_cpu_q;
    logic [7:0]          w_fr, w_fg, w_fb;
    logic                w_show;

    // Palette preload is not modelled here; the RAM starts uninitialised.
    if (SIMFILE != "") begin : g_simfile
    end

    always_comb begin
        w_op = '0;
        for (int i = 0; i < LAYERS; i++)
            w_op[i] = (|layer_pxl[i*8 +: 4]) & gfx_en[i];
    end

    jtframe_prom #(.DW(4), .AW(c_PAW)) u_prom (
        .clk       (clk),
        .i_data    (prog_data),
        .i_wr_addr (prog_addr),
        .i_we      (prom_we),
        .i_rd_addr (r_prom_addr),
        .o_q       (w_prom_q)
    );

    assign w_win = c_WW'(w_prom_q);

    always_comb begin
        w_win_pxl = 8'd0;
        for (int i = 0; i < LAYERS; i++)
            if (w_win == c_WW'(i)) w_win_pxl = r_pxl[i*8 +: 8];
    end

    // Only a non-power-of-two layer count leaves winner codes without a layer
    if ((1 << c_WW) > LAYERS) begin : g_range_chk
        assign w_range_bd = ({1'b0, w_win} >= (c_WW+1)'(LAYERS));
    end else begin : g_no_range_chk
        assign w_range_bd = 1'b0;
    end

    assign w_backdrop = w_prom_q[3] | w_range_bd;
    assign w_pal_addr = w_backdrop ? '0 : PALW'({w_win, w_win_pxl});

    jtframe_dual_ram16 #(.AW(PALW)) u_pal (
        .clk     (clk),
        .i_data0 (cpu_dout),
        .i_addr0 (cpu_addr),
        .i_we0   (~dsn & {2{pal_cs}}),
        .o_q0    (w_cpu_q),
        .i_addr1 (r_pal_addr),
        .o_q1    (w_pal_q)
    );

    jtcop_colmix_fade u_fade (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_lvbl  (LVBL),
        .i_start (fade_start),
        .i_dir   (fade_dir),
        .i_rate  (fade_rate),
        .i_pal   (r_pal),
        .o_busy  (fade_busy),
        .o_red   (w_fr),
        .o_green (w_fg),
        .o_blue  (w_fb)
    );

    // Blanking state travelling alongside the S3 data
    assign w_show = r_hbl_sr[MIX_DLY-2] & r_vbl_sr[MIX_DLY-2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pxl       <= '0;
            r_prom_addr <= '0;
            r_pal_addr  <= '0;
            r_pal       <= 16'd0;
            r_red       <= 8'd0;
            r_green     <= 8'd0;
            r_blue      <= 8'd0;
            r_hbl_sr    <= '0;
            r_vbl_sr    <= '0;
        end else if (pxl_cen) begin
            r_pxl       <= layer_pxl;
            r_prom_addr <= {prisel, layer_pxl[7], w_op};
            r_pal_addr  <= w_pal_addr;
            r_pal       <= w_pal_q;
            r_red       <= w_show ? w_fr : 8'd0;
            r_green     <= w_show ? w_fg : 8'd0;
            r_blue      <= w_show ? w_fb : 8'd0;
            r_hbl_sr    <= {r_hbl_sr[MIX_DLY-2:0], LHBL};
            r_vbl_sr    <= {r_vbl_sr[MIX_DLY-2:0], LVBL};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_cpu_din <= 16'd0;
        else        r_cpu_din <= w_cpu_q;
    end

    assign cpu_din  = r_cpu_din;
    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign LHBL_dly = r_hbl_sr[MIX_DLY-1];
    assign LVBL_dly = r_vbl_sr[MIX_DLY-1];

endmodule
`default_nettype wire

// File: tb/tb_jtcop_colmix_pri.sv
`default_nettype none
// ============================================================================
// tb_jtcop_colmix_pri
// Directed self-checking bench for jtcop_colmix_pri (LAYERS=4, PSW=3,
// PALW=10). PROM modes: 0 = highest opaque layer wins, 1 = sprite on top
// unless its priority bit is set, 2 = always backdrop (data 0xB).
// Revision: 1.0
// ============================================================================
module tb_jtcop_colmix_pri;

    localparam int c_PAW = 8;

    logic        clk = 1'b0;
    logic        rst_n, pxl_cen, LHBL, LVBL;
    logic [31:0] layer_pxl;
    logic [2:0]  prisel;
    logic [3:0]  gfx_en;
    logic        pal_cs;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  dsn;
    logic [15:0] cpu_din;
    logic [7:0]  prog_addr;
    logic [3:0]  prog_data;
    logic        prom_we, fade_start, fade_dir;
    logic [3:0]  fade_rate;
    logic        fade_busy;
    logic [7:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtcop_colmix_pri #(.LAYERS(4), .PSW(3), .PALW(10), .SIMFILE("")) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .layer_pxl(layer_pxl), .prisel(prisel), .gfx_en(gfx_en),
        .pal_cs(pal_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn),
        .cpu_din(cpu_din), .prog_addr(prog_addr), .prog_data(prog_data),
        .prom_we(prom_we), .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_rate(fade_rate), .fade_busy(fade_busy), .red(red), .green(green),
        .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int n);
        repeat (n) begin
            pxl_cen = 1'b1;
            step_clk();
            pxl_cen = 1'b0;
            step_clk();
        end
    endtask

    task automatic frame();
        LVBL = 1'b0;
        step_clk();
        step_clk();
        LVBL = 1'b1;
        step_clk();
    endtask

    task automatic pal_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] ds);
        pal_cs = 1'b1; cpu_addr = a; cpu_dout = d; dsn = ds;
        step_clk();
        pal_cs = 1'b0; dsn = 2'b11;
    endtask

    task automatic set_pix(input logic [7:0] l0, l1, l2, l3);
        layer_pxl = {l3, l2, l1, l0};
    endtask

    function automatic logic [3:0] prom_val(input logic [c_PAW-1:0] a);
        logic [2:0] ps;
        logic       spb;
        logic [3:0] op;
        ps  = a[7:5];
        spb = a[4];
        op  = a[3:0];
        if (ps == 3'd2) return 4'hB;
        if (ps == 3'd1 && op[0] && !spb) return 4'h0;
        for (int i = 3; i >= 0; i--) if (op[i]) return 4'(i);
        return 4'h8;
    endfunction

    task automatic load_prom();
        for (int a = 0; a < 256; a++) begin
            prog_addr = 8'(a);
            prog_data = prom_val(8'(a));
            prom_we   = 1'b1;
            step_clk();
        end
        prom_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pxl_cen = 1'b1;
        set_pix(8'h12, 8'h34, 8'h56, 8'h78);
        step_clk(); step_clk(); step_clk();
        checks++; if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000000", {red, green, blue}); end
        checks++; if ({LHBL_dly, LVBL_dly} !== 2'b00) begin errors++; $display("FAIL reset_blank: got %b want 00", {LHBL_dly, LVBL_dly}); end
        checks++; if (cpu_din !== 16'h0) begin errors++; $display("FAIL reset_cpu_din: got %h want 0000", cpu_din); end
        checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", fade_busy); end
        pxl_cen = 1'b0;
        rst_n = 1'b1;
        step_clk();
    endtask

    task automatic test_winner();
        pal_write(10'h223, 16'h0ABC, 2'b00);
        pal_write(10'h000, 16'h0123, 2'b00);
        prisel = 3'd0; gfx_en = 4'hF; LHBL = 1'b1; LVBL = 1'b1;
        set_pix(8'h00, 8'h15, 8'h23, 8'h00);
        pix(3);
        checks++; if (LHBL_dly !== 1'b0) begin errors++; $display("FAIL blank_latency3: got %b want 0", LHBL_dly); end
        pix(1);
        checks++; if ({LHBL_dly, LVBL_dly} !== 2'b11) begin errors++; $display("FAIL blank_latency4: got %b want 11", {LHBL_dly, LVBL_dly}); end
        checks++; if ({red, green, blue} !== 24'hCCBBAA) begin errors++; $display("FAIL winner_l2: got %h want CCBBAA", {red, green, blue}); end
        set_pix(8'h00, 8'h00, 8'h00, 8'h00);
        pix(4);
        checks++; if ({red, green, blue} !== 24'h332211) begin errors++; $display("FAIL backdrop_transp: got %h want 332211", {red, green, blue}); end
        set_pix(8'h00, 8'h15, 8'h23, 8'h00);
        pix(3);
        checks++; if ({red, green, blue} !== 24'h332211) begin errors++; $display("FAIL latency3_hold: got %h want 332211", {red, green, blue}); end
        pix(1);
        checks++; if ({red, green, blue} !== 24'hCCBBAA) begin errors++; $display("FAIL latency4_new: got %h want CCBBAA", {red, green, blue}); end
        prisel = 3'd2;
        pix(4);
        checks++; if ({red, green, blue} !== 24'h332211) begin errors++; $display("FAIL force_backdrop: got %h want 332211", {red, green, blue}); end
    endtask

    task automatic test_sprite();
        pal_write(10'h111, 16'h0456, 2'b00);
        pal_write(10'h005, 16'h0789, 2'b00);
        prisel = 3'd1;
        set_pix(8'h85, 8'h11, 8'h00, 8'h00);
        pix(4);
        checks++; if ({red, green, blue} !== 24'h665544) begin errors++; $display("FAIL sprite_behind: got %h want 665544", {red, green, blue}); end
        set_pix(8'h05, 8'h11, 8'h00, 8'h00);
        pix(4);
        checks++; if ({red, green, blue} !== 24'h998877) begin errors++; $display("FAIL sprite_front: got %h want 998877", {red, green, blue}); end
    endtask

    task automatic test_cpu_gfx();
        pal_write(10'h2AA, 16'h0000, 2'b00);
        pal_write(10'h2AA, 16'h1234, 2'b01);
        cpu_addr = 10'h2AA; step_clk();
        checks++; if (cpu_din !== 16'h1200) begin errors++; $display("FAIL cpu_upper_byte: got %h want 1200", cpu_din); end
        pal_write(10'h2AA, 16'h5678, 2'b10);
        step_clk();
        checks++; if (cpu_din !== 16'h1278) begin errors++; $display("FAIL cpu_lower_byte: got %h want 1278", cpu_din); end
        cpu_addr = 10'h223; step_clk();
        checks++; if (cpu_din !== 16'h0ABC) begin errors++; $display("FAIL cpu_read_223: got %h want 0ABC", cpu_din); end
        prisel = 3'd0; gfx_en = 4'b1101;
        set_pix(8'h00, 8'h15, 8'h00, 8'h00);
        pix(4);
        checks++; if ({red, green, blue} !== 24'h332211) begin errors++; $display("FAIL gfx_en_only_l1: got %h want 332211", {red, green, blue}); end
        set_pix(8'h05, 8'h15, 8'h00, 8'h00);
        pix(4);
        checks++; if ({red, green, blue} !== 24'h998877) begin errors++; $display("FAIL gfx_en_l1_skip: got %h want 998877", {red, green, blue}); end
        gfx_en = 4'hF;
    endtask

    task automatic test_reset_mid_fade();
        pal_write(10'h3FF, 16'h0FFF, 2'b00);
        prisel = 3'd0;
        set_pix(8'h00, 8'h00, 8'h00, 8'hFF);
        pix(4);
        checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL full_white: got %h want FFFFFF", {red, green, blue}); end
        fade_dir = 1'b0; fade_rate = 4'd0; fade_start = 1'b1;
        step_clk();
        fade_start = 1'b0;
        repeat (9) frame();
        pix(2);
        checks++; if (red !== 8'h6F) begin errors++; $display("FAIL level7_red: got %h want 6F", red); end
        rst_n = 1'b0; step_clk(); rst_n = 1'b1;
        checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", fade_busy); end
        checks++; if ({red, green, blue, LHBL_dly, LVBL_dly} !== 26'h0) begin errors++; $display("FAIL midreset_out: got %h want 0", {red, green, blue, LHBL_dly, LVBL_dly}); end
        pix(4);
        checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL midreset_level16: got %h want FFFFFF", {red, green, blue}); end
    endtask

    task automatic test_fade_in_full();
        fade_dir = 1'b1; fade_rate = 4'd1; fade_start = 1'b1;
        step_clk();
        fade_start = 1'b0; fade_dir = 1'b0; fade_rate = 4'd0;
        checks++; if (fade_busy !== 1'b1) begin errors++; $display("FAIL fadein_armed: got %b want 1", fade_busy); end
        frame();
        checks++; if (fade_busy !== 1'b1) begin errors++; $display("FAIL fadein_wait1: got %b want 1", fade_busy); end
        frame();
        checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL fadein_done: got %b want 0", fade_busy); end
        pix(2);
        checks++; if (red !== 8'hFF) begin errors++; $display("FAIL fadein_level: got %h want FF", red); end
    endtask

    task automatic test_fade_out();
        logic [7:0] exp_r;
        fade_dir = 1'b0; fade_rate = 4'd0; fade_start = 1'b1;
        step_clk();
        fade_start = 1'b0;
        for (int lvl = 15; lvl >= 0; lvl--) begin
            frame();
            pix(2);
            exp_r = (lvl == 0) ? 8'h00 : 8'(16 * lvl - 1);
            checks++; if (red !== exp_r) begin errors++; $display("FAIL fadeout_lvl%0d: got %h want %h", lvl, red, exp_r); end
            if (lvl == 1) begin
                checks++; if (fade_busy !== 1'b1) begin errors++; $display("FAIL fadeout_busy15: got %b want 1", fade_busy); end
            end
        end
        checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL fadeout_busy16: got %b want 0", fade_busy); end
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        layer_pxl = 32'h0; prisel = 3'd0; gfx_en = 4'hF;
        pal_cs = 1'b0; cpu_addr = 10'h0; cpu_dout = 16'h0; dsn = 2'b11;
        prog_addr = 8'h0; prog_data = 4'h0; prom_we = 1'b0;
        fade_start = 1'b0; fade_dir = 1'b0; fade_rate = 4'd0;
        test_reset();
        load_prom();
        test_winner();
        test_sprite();
        test_cpu_gfx();
        test_reset_mid_fade();
        test_fade_in_full();
        test_fade_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
